// File: rtl/switch_bounce_gen.sv
// Mechanical-switch emulator: turns a clean level request into a bouncing sw_out
// (odd toggle burst, settle interval, one-cycle done pulse).
module switch_bounce_gen #(
  parameter int          SEG_CYCLES    = 150000,
  parameter int          BOUNCES       = 3,
  parameter int          SETTLE_CYCLES = 500000,
  parameter bit          JITTER_EN     = 1'b0,
  parameter int          JITTER_W      = 12,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter logic        RESET_LEVEL   = 1'b0,
  parameter int          CNT_W         = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       target_level,
  output logic       sw_out,
  output logic       busy,
  output logic       done,
  output logic [3:0] toggle_cnt
);

  localparam int REM_W = (BOUNCES > 0) ? $clog2(2 * BOUNCES + 1) : 1;

  typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE, DONE} state_t;

  state_t             state_reg, state_next;
  logic [15:0]        lfsr_reg;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [REM_W-1:0]   rem_reg, rem_next;
  logic               sw_reg, sw_next;
  logic [3:0]         tcnt_reg, tcnt_next;
  logic [CNT_W-1:0]   seg_len;
  logic [3:0]         tcnt_inc;
  logic               lfsr_fb;

  // Fibonacci taps 16,14,13,11; free-running so jitter differs between requests
  assign lfsr_fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

  generate
    if (JITTER_EN) begin : g_jitter
      assign seg_len = CNT_W'(SEG_CYCLES) + CNT_W'(lfsr_reg[JITTER_W-1:0]);
    end else begin : g_fixed
      assign seg_len = CNT_W'(SEG_CYCLES);
    end
  endgenerate

  assign tcnt_inc = (tcnt_reg == 4'hF) ? tcnt_reg : tcnt_reg + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      lfsr_reg  <= LFSR_SEED;
      cnt_reg   <= '0;
      rem_reg   <= '0;
      sw_reg    <= RESET_LEVEL;
      tcnt_reg  <= 4'd0;
    end else begin
      state_reg <= state_next;
      lfsr_reg  <= {lfsr_reg[14:0], lfsr_fb};
      cnt_reg   <= cnt_next;
      rem_reg   <= rem_next;
      sw_reg    <= sw_next;
      tcnt_reg  <= tcnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rem_next   = rem_reg;
    sw_next    = sw_reg;
    tcnt_next  = tcnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          if (target_level == sw_reg) begin
            state_next = DONE;
            tcnt_next  = 4'd0;
          end else begin
            sw_next   = ~sw_reg;
            tcnt_next = 4'd1;
            rem_next  = REM_W'(2 * BOUNCES);
            if (BOUNCES == 0) begin
              state_next = SETTLE;
              cnt_next   = CNT_W'(SETTLE_CYCLES);
            end else begin
              state_next = BOUNCE;
              cnt_next   = seg_len;
            end
          end
        end
      end
      BOUNCE: begin
        // counter value 1 marks the last cycle of a segment
        if (cnt_reg <= CNT_W'(1)) begin
          sw_next   = ~sw_reg;
          tcnt_next = tcnt_inc;
          rem_next  = rem_reg - REM_W'(1);
          if (rem_reg <= REM_W'(1)) begin
            state_next = SETTLE;
            cnt_next   = CNT_W'(SETTLE_CYCLES);
          end else begin
            cnt_next = seg_len;
          end
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      SETTLE: begin
        if (cnt_reg <= CNT_W'(1)) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    busy = (state_reg == BOUNCE) || (state_reg == SETTLE);
    done = (state_reg == DONE);
  end

  assign sw_out     = sw_reg;
  assign toggle_cnt = tcnt_reg;

endmodule

// File: tb/tb_switch_bounce_gen.sv
// Directed bench: fixed-timing instance (SEG=10, BOUNCES=2, SETTLE=20) and a
// jittered instance (JITTER_W=3) checked for spacing bounds and final level.
module tb_switch_bounce_gen;

  localparam int SEG     = 10;
  localparam int BNC     = 2;
  localparam int SETTLE  = 20;
  localparam int NTOG    = 2 * BNC + 1;           // 5 toggles
  localparam int LAST_K  = 1 + (NTOG - 1) * SEG;  // 41: last toggle offset from start
  localparam int DONE_K  = LAST_K + SETTLE;       // 61: done offset from start

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_start = 1'b0, a_target = 1'b0;
  logic       a_sw, a_busy, a_done;
  logic [3:0] a_tcnt;
  logic       j_start = 1'b0, j_target = 1'b0;
  logic       j_sw, j_busy, j_done;
  logic [3:0] j_tcnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  switch_bounce_gen #(
    .SEG_CYCLES(SEG), .BOUNCES(BNC), .SETTLE_CYCLES(SETTLE), .JITTER_EN(1'b0),
    .JITTER_W(3), .LFSR_SEED(16'hACE1), .RESET_LEVEL(1'b0), .CNT_W(24)
  ) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .target_level(a_target),
    .sw_out(a_sw), .busy(a_busy), .done(a_done), .toggle_cnt(a_tcnt)
  );

  switch_bounce_gen #(
    .SEG_CYCLES(SEG), .BOUNCES(BNC), .SETTLE_CYCLES(5), .JITTER_EN(1'b1),
    .JITTER_W(3), .LFSR_SEED(16'hACE1), .RESET_LEVEL(1'b0), .CNT_W(24)
  ) dut_j (
    .clk(clk), .reset(reset), .start(j_start), .target_level(j_target),
    .sw_out(j_sw), .busy(j_busy), .done(j_done), .toggle_cnt(j_tcnt)
  );

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (a_sw !== 1'b0) begin n_fail++; $display("FAIL reset_sw got=%b exp=0", a_sw); end
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
    n_checks++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", a_done); end
    n_checks++; if (a_tcnt !== 4'd0) begin n_fail++; $display("FAIL reset_tcnt got=%0d exp=0", a_tcnt); end
    n_checks++; if (j_sw !== 1'b0) begin n_fail++; $display("FAIL reset_jsw got=%b exp=0", j_sw); end
    reset = 1'b0;
    @(negedge clk);
    $display("test_reset: done");
  endtask

  task automatic test_basic_burst();
    int exp_n;
    do_reset();
    a_start = 1'b1; a_target = 1'b1;
    @(negedge clk) a_start = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      exp_n = (k >= LAST_K) ? NTOG : (k - 1) / SEG + 1;
      n_checks++; if (a_sw !== exp_n[0]) begin n_fail++; $display("FAIL burst_sw k=%0d got=%b exp=%b", k, a_sw, exp_n[0]); end
      n_checks++; if (a_busy !== (k <= DONE_K - 1)) begin n_fail++; $display("FAIL burst_busy k=%0d got=%b exp=%b", k, a_busy, (k <= DONE_K - 1)); end
      n_checks++; if (a_done !== (k == DONE_K)) begin n_fail++; $display("FAIL burst_done k=%0d got=%b exp=%b", k, a_done, (k == DONE_K)); end
      n_checks++; if (a_tcnt !== 4'(exp_n)) begin n_fail++; $display("FAIL burst_tcnt k=%0d got=%0d exp=%0d", k, a_tcnt, exp_n); end
      @(negedge clk);
    end
    $display("test_basic_burst: done");
  endtask

  task automatic test_start_while_busy();
    int exp_n;
    do_reset();
    a_start = 1'b1; a_target = 1'b1;
    @(negedge clk) a_start = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      // opposing requests during BOUNCE (k=15) and during DONE (k=61) must be dropped
      if (k == 15 || k == DONE_K) begin a_start = 1'b1; a_target = 1'b0; end
      else begin a_start = 1'b0; a_target = 1'b1; end
      exp_n = (k >= LAST_K) ? NTOG : (k - 1) / SEG + 1;
      n_checks++; if (a_sw !== exp_n[0]) begin n_fail++; $display("FAIL busy_sw k=%0d got=%b exp=%b", k, a_sw, exp_n[0]); end
      n_checks++; if (a_busy !== (k <= DONE_K - 1)) begin n_fail++; $display("FAIL busy_busy k=%0d got=%b exp=%b", k, a_busy, (k <= DONE_K - 1)); end
      n_checks++; if (a_done !== (k == DONE_K)) begin n_fail++; $display("FAIL busy_done k=%0d got=%b exp=%b", k, a_done, (k == DONE_K)); end
      @(negedge clk);
    end
    a_start = 1'b0;
    $display("test_start_while_busy: done");
  endtask

  task automatic test_reset_mid_burst();
    int  seen;
    bit  got;
    do_reset();
    a_start = 1'b1; a_target = 1'b1;
    @(negedge clk) a_start = 1'b0;
    repeat (24) @(negedge clk);           // now at k=25, three toggles in, sw=1
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (a_sw !== 1'b0) begin n_fail++; $display("FAIL midrst_sw got=%b exp=0", a_sw); end
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", a_busy); end
    n_checks++; if (a_tcnt !== 4'd0) begin n_fail++; $display("FAIL midrst_tcnt got=%0d exp=0", a_tcnt); end
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 80; k++) begin
      if (a_done === 1'b1) seen++;
      @(negedge clk);
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL midrst_no_done got=%0d exp=0", seen); end
    a_start = 1'b1; a_target = 1'b1;
    @(negedge clk) a_start = 1'b0;
    got = 1'b0;
    for (int k = 1; k <= 200 && !got; k++) begin
      if (a_done === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL midrst_restart_done got=%b exp=1", got); end
    n_checks++; if (a_sw !== 1'b1) begin n_fail++; $display("FAIL midrst_restart_sw got=%b exp=1", a_sw); end
    n_checks++; if (a_tcnt !== 4'd5) begin n_fail++; $display("FAIL midrst_restart_tcnt got=%0d exp=5", a_tcnt); end
    @(negedge clk);
    $display("test_reset_mid_burst: done");
  endtask

  task automatic test_same_level();
    // sw_out=1 and toggle_cnt=5 left from the previous test
    a_start = 1'b1; a_target = 1'b1;
    @(negedge clk) a_start = 1'b0;
    n_checks++; if (a_done !== 1'b1) begin n_fail++; $display("FAIL same1_done got=%b exp=1", a_done); end
    n_checks++; if (a_tcnt !== 4'd0) begin n_fail++; $display("FAIL same1_tcnt got=%0d exp=0", a_tcnt); end
    n_checks++; if (a_sw !== 1'b1) begin n_fail++; $display("FAIL same1_sw got=%b exp=1", a_sw); end
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL same1_busy got=%b exp=0", a_busy); end
    @(negedge clk);
    n_checks++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL same1_done_clear got=%b exp=0", a_done); end
    do_reset();
    a_start = 1'b1; a_target = 1'b0;
    @(negedge clk) a_start = 1'b0;
    n_checks++; if (a_done !== 1'b1) begin n_fail++; $display("FAIL same0_done got=%b exp=1", a_done); end
    n_checks++; if (a_sw !== 1'b0) begin n_fail++; $display("FAIL same0_sw got=%b exp=0", a_sw); end
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL same0_busy got=%b exp=0", a_busy); end
    n_checks++; if (a_tcnt !== 4'd0) begin n_fail++; $display("FAIL same0_tcnt got=%0d exp=0", a_tcnt); end
    @(negedge clk);
    $display("test_same_level: done");
  endtask

  task automatic test_jitter();
    int  ntog, last_k, k, min_sp, max_sp, sp;
    bit  got, tgt;
    logic prev;
    min_sp = 1000; max_sp = 0;
    for (int r = 0; r < 50; r++) begin
      tgt = (r % 2 == 0);
      j_start = 1'b1; j_target = tgt;
      @(negedge clk) j_start = 1'b0;
      prev = ~tgt; ntog = 0; last_k = 0; got = 1'b0; k = 1;
      while (!got && k < 300) begin
        if (j_sw !== prev) begin
          ntog++;
          if (ntog > 1) begin
            sp = k - last_k;
            if (sp < min_sp) min_sp = sp;
            if (sp > max_sp) max_sp = sp;
            n_checks++; if (sp < 10 || sp > 17) begin n_fail++; $display("FAIL jitter_spacing r=%0d got=%0d exp=10..17", r, sp); end
          end
          last_k = k;
          prev = j_sw;
        end
        if (j_done === 1'b1) got = 1'b1;
        else begin @(negedge clk); k++; end
      end
      n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL jitter_done r=%0d got=%b exp=1", r, got); end
      n_checks++; if (ntog !== NTOG) begin n_fail++; $display("FAIL jitter_ntog r=%0d got=%0d exp=%0d", r, ntog, NTOG); end
      n_checks++; if (j_sw !== tgt) begin n_fail++; $display("FAIL jitter_final r=%0d got=%b exp=%b", r, j_sw, tgt); end
      $display("jitter request %0d target=%b toggles=%0d", r, tgt, ntog);
      @(negedge clk);
    end
    n_checks++; if (min_sp === max_sp) begin n_fail++; $display("FAIL jitter_varies got min=%0d max=%0d exp differing", min_sp, max_sp); end
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_start_while_busy();
    test_reset_mid_burst();
    test_same_level();
    test_jitter();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
